// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues in-order fetches and buffers PC-tagged
// instructions in a circular queue for decode. Optional misaligned-redirect trap: FETCH_MISALIGN_CHECK_EN.
module fetch_queue #(
  parameter int              Width   = 32,
  parameter int              Depth   = 4,
  parameter logic [Width-1:0] ResetPc = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [Width-1:0] mem_addr,
  input  logic             mem_resp_valid,
  input  logic [Width-1:0] mem_resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_pc,
  output logic [Width-1:0] out_instr,
  output logic             out_misaligned
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);

  typedef struct packed {
    logic [Width-1:0] pc;
    logic [Width-1:0] instr;
    logic             filled;
  } entry_t;

  entry_t           q [Depth];
  logic [AW-1:0]    head, tail, fptr;  // fptr: oldest entry still awaiting its response
  logic [CW-1:0]    occ, inflight, drop;
  logic [Width-1:0] pc;
  logic             accept, resp, pop, stall, alloc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic             mis_q [Depth];
  logic             mis_pend, halt;
  assign stall          = mis_pend | halt;
  assign alloc          = mis_pend;
  assign out_misaligned = out_valid & mis_q[head];
`else
  assign stall          = 1'b0;
  assign alloc          = 1'b0;
  assign out_misaligned = 1'b0;
`endif

  assign mem_req_valid = !rst && !redirect_valid && (occ < CW'(Depth)) && (drop == '0) && !stall;
  assign mem_addr      = pc;
  assign accept        = mem_req_valid & mem_req_ready;
  assign resp          = mem_resp_valid;
  assign out_valid     = q[head].filled;
  assign out_pc        = out_valid ? q[head].pc : '0;
  assign out_instr     = out_valid ? q[head].instr : '0;
  assign pop           = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= ResetPc;
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      occ      <= '0;
      inflight <= '0;
      drop     <= '0;
      for (int i = 0; i < Depth; i++) q[i] <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      for (int i = 0; i < Depth; i++) mis_q[i] <= 1'b0;
      mis_pend <= 1'b0;
      halt     <= 1'b0;
`endif
    end else begin
      inflight <= inflight + CW'(accept) - CW'(resp);
      if (redirect_valid) begin
        // Everything still outstanding belongs to the old stream, including a response landing now.
        pc   <= redirect_pc;
        head <= '0;
        tail <= '0;
        fptr <= '0;
        occ  <= '0;
        drop <= inflight + CW'(accept) - CW'(resp);
        for (int i = 0; i < Depth; i++) q[i].filled <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_pend <= |redirect_pc[1:0];
        halt     <= 1'b0;
`endif
      end else begin
        if (accept) begin
          q[tail].pc     <= pc;
          q[tail].filled <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
          mis_q[tail]    <= 1'b0;
`endif
          tail <= tail + AW'(1);
          pc   <= pc + Width'(4);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        // Marker entry stands in for the fetch; no request is ever pending behind it.
        if (mis_pend) begin
          q[tail]     <= '{pc: pc, instr: '0, filled: 1'b1};
          mis_q[tail] <= 1'b1;
          tail        <= tail + AW'(1);
          fptr        <= tail + AW'(1);
          mis_pend    <= 1'b0;
          halt        <= 1'b1;
        end
`endif
        if (resp) begin
          if (drop != '0) begin
            drop <= drop - CW'(1);
          end else begin
            q[fptr].instr  <= mem_resp_data;
            q[fptr].filled <= 1'b1;
            fptr           <= fptr + AW'(1);
          end
        end
        if (pop) begin
          q[head].filled <= 1'b0;
          head           <= head + AW'(1);
        end
        occ <= occ + CW'(accept) + CW'(alloc) - CW'(pop);
      end
    end
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation instruction-fetch front end. Replaces the bare PC flop plus combinational fetch stage with a parametrised unit.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers up to Depth fetched instructions, tagged with their PCs, in a circular queue.
- Presents instructions to decode over a valid/ready handshake and supports branch redirect with flush of queued and in-flight fetches.

Parameters:
- Width, 32, PC and instruction data width in bits.
- Depth, 4, queue entries; power of two, >= 2.
- ResetPc, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_valid  in  1  branch/jump redirect request from execute.
- redirect_pc  in  Width  redirect target.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  Width  fetch address (current PC).
- mem_resp_valid  in  1  response valid; responses return in request order, latency >= 1.
- mem_resp_data  in  Width  fetched instruction.
- out_valid  out  1  head entry holds a fetched instruction.
- out_ready  in  1  decode accepts head.
- out_pc  out  Width  PC of head entry.
- out_instr  out  Width  instruction of head entry.
- out_misaligned  out  1  head entry is a misaligned-target marker (see Optional Feature).

Behaviour:
- Reset (async assert):
  - pc=ResetPc; head=tail=0; all entry filled flags=0.
  - inflight=0, drop=0.
  - Outputs: mem_req_valid=0, out_valid=0, out_pc=0, out_instr=0, out_misaligned=0.
- Occupancy:
  - occ = registered count of allocated entries (pending or filled), 0..Depth.
  - Slot allocated at request acceptance; a pop frees its slot only from the next cycle (no same-cycle reuse).
- Issue:
  - mem_req_valid = !redirect_valid && occ<Depth && drop==0.
  - mem_addr = pc.
  - On accept (valid && ready): write pc into entry[tail], clear filled, tail++ (mod Depth), inflight++, pc <= pc+4.
  - PC arithmetic is modulo 2^Width: 0xFFFFFFFC wraps to 0.
- Response:
  - If drop>0: discard the response, drop--, inflight--.
  - Otherwise fill the oldest pending entry with mem_resp_data, set its filled flag, inflight--.
  - The filled flag is registered, so out_valid rises the cycle after the response.
- Output:
  - out_valid = entry[head].filled.
  - out_pc/out_instr driven from entry[head]; 0 when not valid.
  - Pop on out_valid && out_ready: head++, occ--.
- Redirect (priority over everything else):
  - pc <= redirect_pc.
  - All entries invalidated; head=tail=0; occ=0.
  - drop <= inflight + (accepted request this cycle ? 1 : 0) - (response this cycle ? 1 : 0).
  - No request issued in the redirect cycle.
  - A response arriving in the redirect cycle belongs to the old stream and is discarded.
  - A pop in the redirect cycle is ignored (decode squashes it).
  - First request to the new target issues the next cycle once drop==0. If drop>0, issue waits until all stale responses have drained.
- Simultaneous events:
  - Issue, response and pop may all occur in one cycle; occ and inflight update by the net effect.
  - occ==Depth with a pop that cycle: still no issue.
- Back-to-back redirects: the later one wins; drop accumulates correctly.
- Reset mid-operation: everything cleared immediately; stale responses after reset are ignored only if the memory is also reset (system requirement).

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect whose redirect_pc[1:0]!=0 issues no memory request.
  - The next cycle, it allocates one entry with filled=1, out_misaligned=1, out_pc=redirect_pc, out_instr=0.
  - Issue then halts until the next redirect.
- Undefined:
  - out_misaligned is tied 0.
  - Misaligned targets are fetched as-is.

Test Plan:
- Reset release, mem_req_ready=1, latency-1 memory returning addr^0xA5 -> requests at 0,4,8,...; first out_valid 2 cycles after first accept with out_pc=0, out_instr=0xA5.
- out_ready=0 for 10 cycles, Depth=4 -> exactly 4 requests (0x0..0xC), mem_req_valid=0 afterwards; releasing out_ready pops in order 0,4,8,C with no gaps.
- Latency-3 memory, redirect_valid with redirect_pc=0x100 while 2 requests are in flight -> both stale responses dropped; next out_pc=0x100; no entry from the old stream ever appears.
- pc=0xFFFFFFF8 via redirect -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Response, pop and new accept in the same cycle at occ=3 -> occ stays 3, inflight unchanged, ordering preserved.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> no mem request; out_valid with out_misaligned=1, out_pc=0x102; a redirect to 0x200 resumes normal fetch.
